// File: rtl/sqrt_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the sequential BCD square-root engine:
//   - FSM state encoding (3 bits)
//   - datapath widths and the fixed-point scale factor
//   - per-phase iteration counts
//   - helpers: BCD digit validity check, constant power of ten
// ---------------------------------------------------------------------------
package sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        SCALE = 3'd2,
        ROOT  = 3'd3,
        B2D   = 3'd4,
        FIN   = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam int BIN_W = 20;
    localparam int RAD_W = 40;
    localparam logic [RAD_W-1:0] SCALE_K = 40'd1_000_000;

    localparam int CONV_CYC = 6;
    localparam int ROOT_CYC = 20;
    localparam int B2D_CYC  = 20;

    // True if any nibble of a 6-digit packed BCD word is above 9.
    function automatic logic has_bad_digit(input logic [23:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (d[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Elaboration-time 10^n in the radicand width.
    function automatic logic [RAD_W-1:0] pow10(input int n);
        logic [RAD_W-1:0] r;
        r = 40'd1;
        for (int i = 0; i < n; i++) r = r * 40'd10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// ---------------------------------------------------------------------------
// bin2bcd_dd
// Sequential double-dabble converter: 20-bit binary to 6 packed BCD digits,
// one shift per clock.
// Ports:
//   clock  - system clock
//   reset  - synchronous active-high reset
//   load   - capture bin (also performs the first shift in the same edge)
//   bin    - binary value to convert
//   bcd    - packed BCD result, valid while ready is high
//   ready  - set once all BIN_W shifts are complete; cleared by load
// ---------------------------------------------------------------------------
module bin2bcd_dd
    import sqrt_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [BIN_W-1:0] bin,
    output logic [23:0]      bcd,
    output logic             ready
);

    logic [BIN_W-1:0] r_bin;
    logic [23:0]      r_bcd;
    logic [4:0]       r_cnt;
    logic             r_ready;
    logic [23:0]      w_adj;

    // Add 3 to every digit >= 5 so the following left shift carries correctly.
    function automatic logic [23:0] dd_adjust(input logic [23:0] v);
        logic [23:0] r;
        r = v;
        for (int i = 0; i < 6; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign w_adj = dd_adjust(r_bcd);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else if (load) begin
            // The BCD accumulator starts at zero, so the first shift needs no
            // adjust and can be folded into the load.
            r_bcd   <= {23'd0, bin[BIN_W-1]};
            r_bin   <= {bin[BIN_W-2:0], 1'b0};
            r_cnt   <= 5'd1;
            r_ready <= 1'b0;
        end else if (r_cnt != 5'd0 && !r_ready) begin
            r_bcd   <= {w_adj[22:0], r_bin[BIN_W-1]};
            r_bin   <= {r_bin[BIN_W-2:0], 1'b0};
            r_cnt   <= r_cnt + 5'd1;
            r_ready <= (r_cnt == 5'(B2D_CYC - 1));
        end
    end

    assign bcd   = r_bcd;
    assign ready = r_ready;

endmodule

// File: rtl/sqrt_engine_seq.sv
// ---------------------------------------------------------------------------
// sqrt_engine_seq
// Sequential square root of a 6-digit BCD integer. Result is
// floor(sqrt(N) * 1000) as 6 packed BCD digits (DDD.DDD), truncated.
// Fixed latency: start accepted at T -> done at T+48 (or T+1 on a bad digit).
// Ports:
//   clock   - system clock
//   reset   - synchronous active-high reset; aborts any computation
//   start   - one-cycle request, honoured only in IDLE
//   in_dec  - packed BCD radicand, captured on an accepted start
//   out_dec - packed BCD result, held between computations
//   busy    - high during CONV, SCALE, ROOT and B2D
//   done    - one-cycle pulse in the cycle out_dec/err take new values
//   err     - last request had a non-BCD digit; held until the next result
// ---------------------------------------------------------------------------
module sqrt_engine_seq
    import sqrt_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int FRAC_DIGITS = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [4*DIGITS-1:0] in_dec,
    output logic [4*DIGITS-1:0] out_dec,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [RAD_W-1:0] L_SCALE = pow10(2 * FRAC_DIGITS);

    state_t           r_state, w_next;
    logic [23:0]      r_in, r_out;
    logic [BIN_W-1:0] r_acc, r_root;
    logic [RAD_W-1:0] r_rad, r_rem;
    logic [4:0]       r_cnt;
    logic             r_err;

    logic             w_bad, w_load, w_ready, w_ge;
    logic [23:0]      w_bcd;
    logic [BIN_W-1:0] w_acc_next, w_root_next;
    logic [RAD_W-1:0] w_rem_sh, w_trial, w_rem_sub, w_rad_scaled;

    assign w_bad = has_bad_digit(in_dec);

    // BCD -> binary: digits arrive MSD first from the top of r_in.
    assign w_acc_next = r_acc * 20'd10 + {16'd0, r_in[23:20]};

    assign w_rad_scaled = {20'd0, r_acc} * L_SCALE;

    // Restoring bit-pair root: bring down two radicand bits, try 4*root+1.
    assign w_rem_sh    = {r_rem[RAD_W-3:0], r_rad[RAD_W-1 -: 2]};
    assign w_trial     = {18'd0, r_root, 2'b01};
    assign w_ge        = (w_rem_sh >= w_trial);
    assign w_rem_sub   = w_rem_sh - w_trial;
    assign w_root_next = {r_root[BIN_W-2:0], w_ge};

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = w_bad ? ERR : CONV;
            CONV:  if (r_cnt == 5'(CONV_CYC - 1)) w_next = SCALE;
            SCALE: w_next = ROOT;
            ROOT:  if (r_cnt == 5'(ROOT_CYC - 1)) w_next = B2D;
            B2D:   if (w_ready) w_next = FIN;
            FIN:   w_next = IDLE;
            ERR:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs decoded from state; the converter is loaded with the final
    // root bit in the same edge that computes it.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        w_load = 1'b0;
        case (r_state)
            CONV, SCALE, B2D: busy = 1'b1;
            ROOT: begin
                busy   = 1'b1;
                w_load = (r_cnt == 5'(ROOT_CYC - 1));
            end
            FIN, ERR: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_in   <= '0;
            r_out  <= '0;
            r_acc  <= '0;
            r_root <= '0;
            r_rad  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_in  <= in_dec[23:0];
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (w_bad) begin
                        r_out <= '0;
                        r_err <= 1'b1;
                    end
                end
                CONV: begin
                    r_acc <= w_acc_next;
                    r_in  <= {r_in[19:0], 4'd0};
                    r_cnt <= r_cnt + 5'd1;
                end
                SCALE: begin
                    r_rad  <= w_rad_scaled;
                    r_rem  <= '0;
                    r_root <= '0;
                    r_cnt  <= '0;
                end
                ROOT: begin
                    r_rem  <= w_ge ? w_rem_sub : w_rem_sh;
                    r_root <= w_root_next;
                    r_rad  <= {r_rad[RAD_W-3:0], 2'b00};
                    r_cnt  <= r_cnt + 5'd1;
                end
                B2D: if (w_ready) begin
                    r_out <= w_bcd;
                    r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    bin2bcd_dd u_b2d (
        .clock (clock),
        .reset (reset),
        .load  (w_load),
        .bin   (w_root_next),
        .bcd   (w_bcd),
        .ready (w_ready)
    );

    assign out_dec = r_out;
    assign err     = r_err;

endmodule
